// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES encryption round sequencer
// Fetches round keys one at a time and drives an external combinational round datapath.
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         key_req,
  output logic [3:0]   key_idx,
  input  logic         key_ack,
  input  logic [127:0] key_data,
  output logic [127:0] rnd_in,
  output logic         rnd_last,
  input  logic [127:0] rnd_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEY, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state;
  logic [127:0] st;
  logic [3:0]   r;

  // Status flags are registered alongside the state so no output depends on key_ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      st        <= '0;
      r         <= '0;
      in_ready  <= 1'b1;
      key_req   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st       <= in_data;
            r        <= 4'd0;
            state    <= KEY;
            in_ready <= 1'b0;
            key_req  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        KEY: begin
          if (key_ack) begin
            if (r == 4'd0) begin
              st <= st ^ key_data;
              r  <= 4'd1;
            end else begin
              st <= rnd_out ^ key_data;
              if (r == LAST) begin
                state     <= DONE;
                key_req   <= 1'b0;
                out_valid <= 1'b1;
              end else begin
                r <= r + 4'd1;
              end
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          key_req   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign key_idx  = r;
  assign rnd_in   = st;
  assign rnd_last = (r == LAST);
  assign out_data = st;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - bench for aes_round_sequencer (NR=10 and NR=14 instances)
// Reference AES round datapath and key schedule drive the DUT; results checked against FIPS-197 vectors.
module tb_aes_round_sequencer;

  logic         clk, resetn, sel;
  logic         in_valid, key_ack, out_ready;
  logic [127:0] in_data;

  logic         in_ready10, key_req10, rnd_last10, out_valid10, busy10;
  logic [3:0]   key_idx10;
  logic [127:0] rnd_in10, out_data10, key_data10, rnd_out10;
  logic         in_ready14, key_req14, rnd_last14, out_valid14, busy14;
  logic [3:0]   key_idx14;
  logic [127:0] rnd_in14, out_data14, key_data14, rnd_out14;

  wire in_valid10 = in_valid & ~sel;
  wire in_valid14 = in_valid & sel;
  wire key_ack10  = key_ack & ~sel;
  wire key_ack14  = key_ack & sel;

  wire         c_in_ready  = sel ? in_ready14  : in_ready10;
  wire         c_key_req   = sel ? key_req14   : key_req10;
  wire [3:0]   c_key_idx   = sel ? key_idx14   : key_idx10;
  wire         c_rnd_last  = sel ? rnd_last14  : rnd_last10;
  wire         c_out_valid = sel ? out_valid14 : out_valid10;
  wire [127:0] c_out_data  = sel ? out_data14  : out_data10;
  wire         c_busy      = sel ? busy14      : busy10;

  aes_round_sequencer #(.NR(10)) dut10 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid10), .in_ready(in_ready10), .in_data(in_data),
    .key_req(key_req10), .key_idx(key_idx10), .key_ack(key_ack10), .key_data(key_data10),
    .rnd_in(rnd_in10), .rnd_last(rnd_last10), .rnd_out(rnd_out10),
    .out_valid(out_valid10), .out_ready(out_ready), .out_data(out_data10), .busy(busy10)
  );

  aes_round_sequencer #(.NR(14)) dut14 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid14), .in_ready(in_ready14), .in_data(in_data),
    .key_req(key_req14), .key_idx(key_idx14), .key_ack(key_ack14), .key_data(key_data14),
    .rnd_in(rnd_in14), .rnd_last(rnd_last14), .rnd_out(rnd_out14),
    .out_valid(out_valid14), .out_ready(out_ready), .out_data(out_data14), .busy(busy14)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference AES model ----------------
  logic [7:0]   sb[256];
  logic [31:0]  w[60];
  logic [127:0] rk10[16];
  logic [127:0] rk14[16];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] rc;
    rc = 8'h01;
    for (int j = 1; j < n; j++) rc = xt(rc);
    return rc;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0]   a[16];
    logic [7:0]   b[16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) a[r] = b[4*c+r];
        b[4*c+0] = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
        b[4*c+1] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
        b[4*c+2] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
        b[4*c+3] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o;
  endfunction

  task automatic expand(input logic [255:0] key, input bit big);
    int nk, nr;
    logic [31:0] t;
    nk = big ? 8 : 4;
    nr = big ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon(i/nk), 24'h000000};
      else if (big && (i % nk == 4)) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k <= nr; k++) begin
      if (big) rk14[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      else     rk10[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    end
  endtask

  function automatic logic [127:0] enc10(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk10[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, r == 10) ^ rk10[r];
    return s;
  endfunction

  // Key schedule and round datapath responses; the DUT samples them on the following rising edge.
  always @(negedge clk) begin
    key_data10 = rk10[key_idx10];
    key_data14 = rk14[key_idx14];
    rnd_out10  = aes_round(rnd_in10, rnd_last10);
    rnd_out14  = aes_round(rnd_in14, rnd_last14);
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  typedef struct {
    logic [255:0] key;
    bit           big;
    logic [127:0] pt;
    logic [127:0] ct;
    int           maxw;
    int           hold;
  } vec_t;

  localparam logic [127:0] K128_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

  vec_t tbl[6];

  task automatic run_block(input logic [127:0] pt, input logic [127:0] want_ct, input int nr,
                           input int maxw, input int hold);
    int cyc, waits, total, exp_idx;
    bit seq_ok, last_ok, stable_ok;
    logic [127:0] ct;
    seq_ok = 1'b1; last_ok = 1'b1; stable_ok = 1'b1;
    total = 0; exp_idx = 0; cyc = 0;
    waits = $urandom_range(maxw, 0);
    chk("idle_in_ready", 128'(c_in_ready), 128'(1));
    in_data = pt; in_valid = 1'b1; key_ack = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!c_out_valid && cyc < 200) begin
      if (c_rnd_last !== (c_key_idx == 4'(nr))) last_ok = 1'b0;
      key_ack = 1'b0;
      if (c_key_req) begin
        if (waits > 0) begin
          waits--;
          total++;
        end else begin
          key_ack = 1'b1;
          if (c_key_idx != 4'(exp_idx)) seq_ok = 1'b0;
          exp_idx++;
          waits = $urandom_range(maxw, 0);
        end
      end
      @(negedge clk);
      cyc++;
    end
    key_ack = 1'b0;
    chk("out_valid_seen", 128'(c_out_valid), 128'(1));
    chk("ciphertext", c_out_data, want_ct);
    chk("latency", 128'(cyc), 128'(nr + 1 + total));
    chk("key_idx_order", 128'(seq_ok), 128'(1));
    chk("key_req_count", 128'(exp_idx), 128'(nr + 1));
    chk("rnd_last_decode", 128'(last_ok), 128'(1));
    ct = c_out_data;
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      @(negedge clk);
      if (!c_out_valid || c_out_data !== ct || c_in_ready || c_key_req || !c_busy) stable_ok = 1'b0;
    end
    if (hold > 0) chk("done_hold_stable", 128'(stable_ok), 128'(1));
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", 128'(c_out_valid), 128'(0));
    chk("release_in_ready", 128'(c_in_ready), 128'(1));
    chk("release_busy", 128'(c_busy), 128'(0));
  endtask

  initial begin
    int cyc;
    bit quiet;
    logic [127:0] ct1, pt2;

    resetn = 1'b0; sel = 1'b0; in_valid = 1'b0; key_ack = 1'b0; out_ready = 1'b0; in_data = '0;
    for (int i = 0; i < 256; i++) sb[i] = calc_sbox(8'(i));

    tbl[0] = '{{K128_C1, 128'h0}, 1'b0, PT_C, CT_C1, 0, 0};
    tbl[1] = '{{K128_C1, 128'h0}, 1'b0, PT_C, CT_C1, 3, 0};
    tbl[2] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0,
               128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 0, 20};
    tbl[3] = '{256'h0, 1'b0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2, 3};
    tbl[4] = '{K256_C3, 1'b1, PT_C, CT_C3, 0, 0};
    tbl[5] = '{K256_C3, 1'b1, PT_C, CT_C3, 3, 1};
    expand(tbl[0].key, tbl[0].big);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready10), 128'(1));
    chk("rst_key_req", 128'(key_req10), 128'(0));
    chk("rst_key_idx", 128'(key_idx10), 128'(0));
    chk("rst_out_valid", 128'(out_valid10), 128'(0));
    chk("rst_busy", 128'(busy10), 128'(0));
    chk("rst_state_reg", out_data10, 128'h0);
    resetn = 1'b1;

    // first block is offered on the very first edge after release
    for (int v = 0; v < 6; v++) begin
      sel = tbl[v].big;
      expand(tbl[v].key, tbl[v].big);
      run_block(tbl[v].pt, tbl[v].ct, tbl[v].big ? 14 : 10, tbl[v].maxw, tbl[v].hold);
    end

    // reset in the middle of a block
    sel = 1'b0;
    expand({K128_C1, 128'h0}, 1'b0);
    in_data = PT_C; in_valid = 1'b1; key_ack = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 50 && key_idx10 != 4'd5; i++) @(negedge clk);
    chk("abort_reached_r5", 128'(key_idx10), 128'(5));
    resetn = 1'b0;
    #1;
    chk("abort_key_req", 128'(key_req10), 128'(0));
    chk("abort_key_idx", 128'(key_idx10), 128'(0));
    chk("abort_busy", 128'(busy10), 128'(0));
    chk("abort_out_valid", 128'(out_valid10), 128'(0));
    chk("abort_in_ready", 128'(in_ready10), 128'(1));
    key_ack = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    quiet = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (out_valid10 || busy10) quiet = 1'b0;
    end
    chk("abort_no_output", 128'(quiet), 128'(1));
    run_block(PT_C, CT_C1, 10, 0, 0);

    // back-to-back blocks with in_valid, out_ready and key_ack held high
    pt2 = 128'h0;
    in_data = PT_C; in_valid = 1'b1; key_ack = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!out_valid10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_latency1", 128'(cyc), 128'(11));
    ct1 = out_data10;
    chk("b2b_ct1", ct1, CT_C1);
    in_data = pt2;
    @(negedge clk);
    chk("b2b_idle_gap_ready", 128'(in_ready10), 128'(1));
    chk("b2b_idle_gap_busy", 128'(busy10), 128'(0));
    @(negedge clk);
    chk("b2b_second_accept", 128'(busy10), 128'(1));
    chk("b2b_second_in_ready", 128'(in_ready10), 128'(0));
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_latency2", 128'(cyc), 128'(11));
    chk("b2b_ct2", out_data10, enc10(pt2));
    @(negedge clk);
    out_ready = 1'b0; key_ack = 1'b0;
    chk("b2b_final_out_valid", 128'(out_valid10), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
